// File: rtl/qpi_dsm_writer.sv
// Purpose: writes the AFU_ID to DSM line 0 once the DSM base is known, then forwards
//          status-line writes (lines 1-63) onto the TX1 write channel.
// Latency: accept at cycle N -> write at N+1 when unthrottled; next accept no earlier than N+2.
// Backpressure: st_ready falls at MAX_OUTSTANDING un-acked writes; tx1_almostfull holds any pending write.
//
// Ports:
//   clk, resetb            clock, synchronous active-low reset
//   dsm_base[_valid]       DSM byte base address from the CSR block, and its programmed flag
//   st_valid/st_ready      status-write request handshake; st_line selects the line, st_data the payload
//   tx1_*                  registered write request (addr in cache lines, 512-bit data, mdata tag)
//   rx0/rx1_wrvalid        write completions, each retiring one outstanding write
//   id_written             sticky flag: the AFU_ID write has been acknowledged
//   outstanding            current count of un-acknowledged writes
module qpi_dsm_writer #(
    parameter logic [127:0] AFU_ID          = 128'h0,
    parameter int           MAX_OUTSTANDING = 4,
    parameter logic [12:0]  MDATA_TAG       = 13'h1D5
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic [63:0]  dsm_base,
    input  logic         dsm_base_valid,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [5:0]   st_line,
    input  logic [511:0] st_data,
    output logic         tx1_wrvalid,
    output logic [31:0]  tx1_addr,
    output logic [511:0] tx1_data,
    output logic [12:0]  tx1_mdata,
    input  logic         tx1_almostfull,
    input  logic         rx0_wrvalid,
    input  logic         rx1_wrvalid,
    output logic         id_written,
    output logic [3:0]   outstanding
);

    typedef enum logic [2:0] {IDLE, ID_WR, ID_ACK, RUN, ST_WR} state_t;

    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    state_t         state_q;
    logic           tx1_wrvalid_q;
    logic [31:0]    tx1_addr_q;
    logic [511:0]   tx1_data_q;
    logic [12:0]    tx1_mdata_q;
    logic           id_written_q;
    logic [3:0]     outstanding_q;
    logic [3:0]     outstanding_d;
    logic [5:0]     line_q;
    logic [511:0]   data_q;
    logic           pend_q;         // request accepted under almostfull, write still owed

    logic           accept_c;
    logic           issue_c;
    logic [31:0]    iss_addr_c;
    logic [511:0]   iss_data_c;
    logic [4:0]     sum_c;
    logic [4:0]     dec_c;
    logic [4:0]     diff_c;

    // Only the cache-line address bits [37:6] of the byte base are used.
    logic           unused_base;
    assign unused_base = ^{dsm_base[63:38], dsm_base[5:0]};

    assign st_ready = resetb && (state_q == RUN) && (outstanding_q < MAX_OUT);
    assign accept_c = st_valid && st_ready;

    // Issue decision. A request accepted while almostfull is low goes out on
    // the accept edge itself, which is what gives the one-cycle latency; the
    // ST_WR state then only re-tries requests that were accepted under
    // almostfull. The accept gate already guarantees room for one more write.
    always_comb begin
        issue_c    = 1'b0;
        iss_addr_c = dsm_base[37:6];
        iss_data_c = {384'b0, AFU_ID};
        case (state_q)
            ID_WR: begin
                issue_c = !tx1_almostfull && (outstanding_q < MAX_OUT);
            end
            RUN: begin
                if (accept_c && (st_line != 6'd0) && !tx1_almostfull) begin
                    issue_c    = 1'b1;
                    iss_addr_c = dsm_base[37:6] + {26'b0, st_line};
                    iss_data_c = st_data;
                end
            end
            ST_WR: begin
                if (pend_q && !tx1_almostfull) begin
                    issue_c    = 1'b1;
                    iss_addr_c = dsm_base[37:6] + {26'b0, line_q};
                    iss_data_c = data_q;
                end
            end
            default: ;
        endcase
    end

    // Issue and both completions net out in one cycle; excess decrements clamp at zero.
    always_comb begin
        sum_c  = {1'b0, outstanding_q} + {4'b0, issue_c};
        dec_c  = {4'b0, rx0_wrvalid} + {4'b0, rx1_wrvalid};
        diff_c = sum_c - dec_c;
        outstanding_d = (sum_c > dec_c) ? diff_c[3:0] : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q       <= IDLE;
            tx1_wrvalid_q <= 1'b0;
            tx1_addr_q    <= '0;
            tx1_data_q    <= '0;
            tx1_mdata_q   <= '0;
            id_written_q  <= 1'b0;
            outstanding_q <= '0;
            line_q        <= '0;
            data_q        <= '0;
            pend_q        <= 1'b0;
        end else begin
            tx1_wrvalid_q <= issue_c;
            outstanding_q <= outstanding_d;
            if (issue_c) begin
                tx1_addr_q  <= iss_addr_c;
                tx1_data_q  <= iss_data_c;
                tx1_mdata_q <= MDATA_TAG;
            end
            case (state_q)
                IDLE: begin
                    if (dsm_base_valid) state_q <= ID_WR;
                end
                ID_WR: begin
                    if (issue_c) state_q <= ID_ACK;
                end
                ID_ACK: begin
                    if (outstanding_q == 4'd0) begin
                        state_q      <= RUN;
                        id_written_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept_c) begin
                        state_q <= ST_WR;
                        line_q  <= st_line;
                        data_q  <= st_data;
                        // line 0 belongs to the ID and is silently dropped
                        pend_q  <= (st_line != 6'd0) && tx1_almostfull;
                    end
                end
                ST_WR: begin
                    if (!pend_q || !tx1_almostfull) begin
                        state_q <= RUN;
                        pend_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx1_wrvalid = tx1_wrvalid_q;
    assign tx1_addr    = tx1_addr_q;
    assign tx1_data    = tx1_data_q;
    assign tx1_mdata   = tx1_mdata_q;
    assign id_written  = id_written_q;
    assign outstanding = outstanding_q;

endmodule

// File: tb/tb_qpi_dsm_writer.sv
// Purpose: directed bench for qpi_dsm_writer; expected writes are queued as stimulus is issued
//          and a negedge monitor pops and compares every tx1 write the DUT presents.
// Latency/backpressure scenarios: ID write, almostfull hold, outstanding limit, line 0 drop, wrap, reset.
module tb_qpi_dsm_writer;

    localparam logic [127:0] AFU = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [12:0]  TAG = 13'h1D5;

    logic         clk;
    logic         resetb;
    logic [63:0]  dsm_base;
    logic         dsm_base_valid;
    logic         st_valid;
    logic         st_ready;
    logic [5:0]   st_line;
    logic [511:0] st_data;
    logic         tx1_wrvalid;
    logic [31:0]  tx1_addr;
    logic [511:0] tx1_data;
    logic [12:0]  tx1_mdata;
    logic         tx1_almostfull;
    logic         rx0_wrvalid;
    logic         rx1_wrvalid;
    logic         id_written;
    logic [3:0]   outstanding;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0]  addr;
        logic [511:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    qpi_dsm_writer #(
        .AFU_ID(AFU),
        .MAX_OUTSTANDING(4),
        .MDATA_TAG(TAG)
    ) dut (
        .clk(clk),
        .resetb(resetb),
        .dsm_base(dsm_base),
        .dsm_base_valid(dsm_base_valid),
        .st_valid(st_valid),
        .st_ready(st_ready),
        .st_line(st_line),
        .st_data(st_data),
        .tx1_wrvalid(tx1_wrvalid),
        .tx1_addr(tx1_addr),
        .tx1_data(tx1_data),
        .tx1_mdata(tx1_mdata),
        .tx1_almostfull(tx1_almostfull),
        .rx0_wrvalid(rx0_wrvalid),
        .rx1_wrvalid(rx1_wrvalid),
        .id_written(id_written),
        .outstanding(outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] mk_data(input logic [5:0] ln);
        logic [31:0] w;
        w = {24'hC0FFEE, 2'b00, ln};
        return {16{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [511:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Holds a request until the DUT takes it (bounded); returns just after the accept edge.
    task automatic send(input logic [5:0] ln);
        bit acc;
        acc = 1'b0;
        st_valid = 1'b1;
        st_line  = ln;
        st_data  = mk_data(ln);
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = st_ready;
            tick();
        end
        st_valid = 1'b0;
        n_vec++;
        if (!acc) begin
            n_err++;
            $display("FAIL send_line_%0d: request not accepted within 20 cycles", ln);
        end
    endtask

    task automatic wait_id();
        for (int i = 0; i < 20 && !id_written; i++) tick();
        chk("id_written", 512'(id_written), 512'(1));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wrvalid"}, 512'(tx1_wrvalid), 512'(0));
        chk({tag, "_st_ready"}, 512'(st_ready), 512'(0));
        chk({tag, "_id_written"}, 512'(id_written), 512'(0));
        chk({tag, "_outstanding"}, 512'(outstanding), 512'(0));
        chk({tag, "_addr"}, 512'(tx1_addr), 512'(0));
        chk({tag, "_data"}, tx1_data, 512'(0));
        chk({tag, "_mdata"}, 512'(tx1_mdata), 512'(0));
    endtask

    // Scoreboard monitor: every presented write must match the oldest expectation.
    always @(negedge clk) begin
        if (resetb && tx1_wrvalid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: addr %0h presented with nothing expected", tx1_addr);
            end else begin
                mon_e = exp_q.pop_front();
                if (tx1_addr !== mon_e.addr || tx1_data !== mon_e.data || tx1_mdata !== TAG) begin
                    n_err++;
                    $display("FAIL write: got addr %0h mdata %0h data %0h, expected addr %0h mdata %0h data %0h",
                             tx1_addr, tx1_mdata, tx1_data[127:0], mon_e.addr, TAG, mon_e.data[127:0]);
                end
            end
        end
    end

    initial begin
        int seen;
        resetb = 1'b0; dsm_base = '0; dsm_base_valid = 1'b0;
        st_valid = 1'b0; st_line = '0; st_data = '0;
        tx1_almostfull = 1'b0; rx0_wrvalid = 1'b0; rx1_wrvalid = 1'b0;
        repeat (3) tick();
        chk_zero("reset");

        resetb = 1'b1;
        tick();
        chk("idle_no_write", 512'(tx1_wrvalid), 512'(0));

        // ID write to line 0 at base 0x1000 -> cache-line address 0x40
        dsm_base = 64'h1000;
        expect_wr(32'h40, {384'b0, AFU});
        dsm_base_valid = 1'b1;
        for (int i = 0; i < 10 && !tx1_wrvalid; i++) tick();
        chk("id_wr_seen", 512'(tx1_wrvalid), 512'(1));
        chk("id_outstanding", 512'(outstanding), 512'(1));
        chk("id_not_yet_written", 512'(id_written), 512'(0));
        tick();
        rx0_wrvalid = 1'b1;
        tick();
        rx0_wrvalid = 1'b0;
        wait_id();
        dsm_base_valid = 1'b0;          // a drop after IDLE must not matter
        chk("run_st_ready", 512'(st_ready), 512'(1));

        // Outstanding limit: four writes go, then st_ready closes
        for (int k = 1; k <= 4; k++) begin
            expect_wr(32'h40 + 32'(k), mk_data(6'(k)));
            send(6'(k));
        end
        tick();
        chk("limit_outstanding", 512'(outstanding), 512'(4));
        chk("limit_st_ready", 512'(st_ready), 512'(0));
        st_valid = 1'b1; st_line = 6'd5; st_data = mk_data(6'd5);
        repeat (3) tick();
        chk("limit_blocked_ready", 512'(st_ready), 512'(0));
        chk("limit_blocked_outstanding", 512'(outstanding), 512'(4));
        expect_wr(32'h45, mk_data(6'd5));
        rx1_wrvalid = 1'b1;
        tick();
        rx1_wrvalid = 1'b0;
        chk("limit_after_rx1", 512'(outstanding), 512'(3));
        send(6'd5);
        tick();
        chk("limit_refilled", 512'(outstanding), 512'(4));
        st_valid = 1'b1; st_line = 6'd6; st_data = mk_data(6'd6);
        repeat (3) tick();
        chk("sixth_blocked", 512'(st_ready), 512'(0));
        st_valid = 1'b0;

        // Two completions in one cycle
        rx0_wrvalid = 1'b1; rx1_wrvalid = 1'b1;
        tick();
        rx0_wrvalid = 1'b0; rx1_wrvalid = 1'b0;
        chk("drain_two", 512'(outstanding), 512'(2));

        // Issue coinciding with both completions at outstanding=2
        expect_wr(32'h47, mk_data(6'd7));
        st_valid = 1'b1; st_line = 6'd7; st_data = mk_data(6'd7);
        rx0_wrvalid = 1'b1; rx1_wrvalid = 1'b1;
        tick();
        st_valid = 1'b0; rx0_wrvalid = 1'b0; rx1_wrvalid = 1'b0;
        chk("coincide_outstanding", 512'(outstanding), 512'(1));
        chk("coincide_wrvalid", 512'(tx1_wrvalid), 512'(1));
        tick();

        // Two decrements at outstanding=1 clamp at zero
        rx0_wrvalid = 1'b1; rx1_wrvalid = 1'b1;
        tick();
        rx0_wrvalid = 1'b0; rx1_wrvalid = 1'b0;
        chk("saturate_zero", 512'(outstanding), 512'(0));

        // Line 0 is accepted but never written
        send(6'd0);
        chk("line0_no_write", 512'(tx1_wrvalid), 512'(0));
        tick();
        chk("line0_outstanding", 512'(outstanding), 512'(0));

        // Address wrap: base[37:6] = FFFFFFFF, +1 -> 0
        dsm_base = 64'hFF_FFFF_FFC0;
        expect_wr(32'h0, mk_data(6'd1));
        send(6'd1);
        tick();

        // almostfull in ST_WR holds the write; a base change lands on it
        tx1_almostfull = 1'b1;
        send(6'd3);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (tx1_wrvalid) seen++;
            tick();
        end
        chk("stwr_hold_no_write", 512'(seen), 512'(0));
        dsm_base = 64'h1000;
        expect_wr(32'h43, mk_data(6'd3));
        tx1_almostfull = 1'b0;
        tick();
        chk("stwr_release_write", 512'(tx1_wrvalid), 512'(1));
        tick();
        rx0_wrvalid = 1'b1; rx1_wrvalid = 1'b1;
        tick();
        rx0_wrvalid = 1'b0; rx1_wrvalid = 1'b0;
        chk("drain_zero", 512'(outstanding), 512'(0));

        // Mid-operation reset with three writes outstanding
        for (int k = 8; k <= 10; k++) begin
            expect_wr(32'h40 + 32'(k), mk_data(6'(k)));
            send(6'(k));
        end
        tick();
        chk("pre_reset_outstanding", 512'(outstanding), 512'(3));
        resetb = 1'b0;
        tick();
        chk_zero("midreset");

        // ID write re-runs; almostfull held for 10 cycles in ID_WR
        tx1_almostfull = 1'b1;
        dsm_base_valid = 1'b1;
        tick();
        resetb = 1'b1;
        expect_wr(32'h40, {384'b0, AFU});
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx1_wrvalid) seen++;
        end
        chk("idwr_af_hold", 512'(seen), 512'(0));
        tx1_almostfull = 1'b0;
        tick();
        chk("idwr_after_af_fall", 512'(tx1_wrvalid), 512'(1));
        rx0_wrvalid = 1'b1;
        tick();
        rx0_wrvalid = 1'b0;
        wait_id();

        repeat (3) tick();
        chk("scoreboard_empty", 512'(exp_q.size()), 512'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
